ar_arbiter: RTL

- Read-address-channel arbiter for the AXI interconnect.
- Shares one AR path between two masters (M0 instruction fetch, M1 data) using round-robin.
- Tags each forwarded ID with a one-hot master tag and drives the existing AR broadcast/decode stage.
- Completes the AR handshake itself for addresses outside the slave map and issues a DECERR request to the default slave.

---
 rtl/axi_pkg.sv | 31 +++
 rtl/rr_arbiter2.sv | 22 ++
 rtl/ar_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI interconnect constants: widths, master tags, slave address map and
// the AR/AW arbiter state encoding.
package axi_pkg;

  localparam int ID_BITS   = 4;
  localparam int IDS_BITS  = 8;
  localparam int ADDR_BITS = 32;
  localparam int LEN_BITS  = 4;
  localparam int SIZE_BITS = 3;
  localparam int TAG_BITS  = 4;

  localparam logic [TAG_BITS-1:0] TAG_M0 = 4'b0001;
  localparam logic [TAG_BITS-1:0] TAG_M1 = 4'b0010;

  localparam logic [ADDR_BITS-1:0] S0_LO = 32'h0000_0000;
  localparam logic [ADDR_BITS-1:0] S0_HI = 32'h0000_FFFF;
  localparam logic [ADDR_BITS-1:0] S1_LO = 32'h0001_0000;
  localparam logic [ADDR_BITS-1:0] S1_HI = 32'h0001_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_DECERR = 2'd2
  } ar_state_e;

  // S0 starts at zero, so its lower bound needs no unsigned compare.
  function automatic logic addr_mapped(input logic [ADDR_BITS-1:0] addr);
    return (addr <= S0_HI) || ((addr >= S1_LO) && (addr <= S1_HI));
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin select: a lone requester wins, a tie goes to the master
// that did not win last.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       valid_o,
  output logic       sel_o
);

  // Selection is purely combinational; the caller registers the winner.
  always_comb begin
    valid_o = |req_i;
    if (req_i == 2'b11) begin
      sel_o = ~last_grant_i;
    end else if (req_i[1]) begin
      sel_o = 1'b1;
    end else begin
      sel_o = 1'b0;
    end
  end

endmodule

// File: rtl/ar_arbiter.sv
// Read-address arbiter: shares one AR path between M0 (fetch) and M1 (data),
// tags forwarded IDs per master, and diverts unmapped addresses to the default slave.
module ar_arbiter #(
  parameter int ID_BITS   = axi_pkg::ID_BITS,
  parameter int IDS_BITS  = axi_pkg::IDS_BITS,
  parameter int ADDR_BITS = axi_pkg::ADDR_BITS,
  parameter int LEN_BITS  = axi_pkg::LEN_BITS,
  parameter int SIZE_BITS = axi_pkg::SIZE_BITS
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic [ID_BITS-1:0]   ARID_M0,
  input  logic [ADDR_BITS-1:0] ARADDR_M0,
  input  logic [LEN_BITS-1:0]  ARLEN_M0,
  input  logic [SIZE_BITS-1:0] ARSIZE_M0,
  input  logic [1:0]           ARBURST_M0,
  input  logic                 ARVALID_M0,
  output logic                 ARREADY_M0,
  input  logic [ID_BITS-1:0]   ARID_M1,
  input  logic [ADDR_BITS-1:0] ARADDR_M1,
  input  logic [LEN_BITS-1:0]  ARLEN_M1,
  input  logic [SIZE_BITS-1:0] ARSIZE_M1,
  input  logic [1:0]           ARBURST_M1,
  input  logic                 ARVALID_M1,
  output logic                 ARREADY_M1,
  output logic [IDS_BITS-1:0]  ARID,
  output logic [ADDR_BITS-1:0] ARADDR,
  output logic [LEN_BITS-1:0]  ARLEN,
  output logic [SIZE_BITS-1:0] ARSIZE,
  output logic [1:0]           ARBURST,
  output logic                 ARVALID,
  input  logic                 ARREADY,
  output logic                 DEC_VALID,
  output logic [IDS_BITS-1:0]  DEC_ID,
  output logic [LEN_BITS-1:0]  DEC_LEN,
  input  logic                 DEC_READY
);
  import axi_pkg::*;

  ar_state_e state_q, state_d;
  logic      grant_q, grant_d;
  logic      last_grant_q, last_grant_d;

  logic                 req_any_s;
  logic                 sel_s;
  logic [ADDR_BITS-1:0] sel_addr_s;
  logic                 g_valid_s;
  logic [ID_BITS-1:0]   g_id_s;
  logic [IDS_BITS-1:0]  g_tagged_id_s;
  logic [LEN_BITS-1:0]  g_len_s;

  rr_arbiter2 u_rr (
    .req_i        ({ARVALID_M1, ARVALID_M0}),
    .last_grant_i (last_grant_q),
    .valid_o      (req_any_s),
    .sel_o        (sel_s)
  );

  assign sel_addr_s    = sel_s   ? ARADDR_M1  : ARADDR_M0;
  assign g_valid_s     = grant_q ? ARVALID_M1 : ARVALID_M0;
  assign g_id_s        = grant_q ? ARID_M1    : ARID_M0;
  assign g_len_s       = grant_q ? ARLEN_M1   : ARLEN_M0;
  assign g_tagged_id_s = {(grant_q ? TAG_M1 : TAG_M0), g_id_s};

  // Next-state and output decode; outputs are quiet in IDLE, giving one bubble per transfer.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ARVALID      = 1'b0;
    ARID         = '0;
    ARADDR       = '0;
    ARLEN        = '0;
    ARSIZE       = '0;
    ARBURST      = 2'b00;
    ARREADY_M0   = 1'b0;
    ARREADY_M1   = 1'b0;
    DEC_VALID    = 1'b0;
    DEC_ID       = '0;
    DEC_LEN      = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_any_s) begin
          grant_d = sel_s;
          state_d = addr_mapped(sel_addr_s) ? ST_GRANT : ST_DECERR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        ARVALID = g_valid_s;
        ARID    = g_tagged_id_s;
        ARADDR  = grant_q ? ARADDR_M1  : ARADDR_M0;
        ARLEN   = g_len_s;
        ARSIZE  = grant_q ? ARSIZE_M1  : ARSIZE_M0;
        ARBURST = grant_q ? ARBURST_M1 : ARBURST_M0;
        if (grant_q) begin
          ARREADY_M1 = ARREADY;
        end else begin
          ARREADY_M0 = ARREADY;
        end
        if (g_valid_s && ARREADY) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end else begin
          state_d      = ST_GRANT;
        end
      end
      ST_DECERR: begin
        // Master accept is tied to the default slave's accept so both complete together.
        DEC_VALID = 1'b1;
        DEC_ID    = g_tagged_id_s;
        DEC_LEN   = g_len_s;
        if (grant_q) begin
          ARREADY_M1 = DEC_READY;
        end else begin
          ARREADY_M0 = DEC_READY;
        end
        if (DEC_READY) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end else begin
          state_d      = ST_DECERR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; last_grant resets to M1 so M0 wins the first tie.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule
